// File: rtl/thor2023_mmu_pkg.sv
// Shared MMU definitions: L1 TLB geometry defaults and the sweep FSM state type.
package thor2023_mmu_pkg;

  localparam int unsigned TLB_L1_ENTRIES = 64;
  localparam int unsigned TLB_L1_WAYS    = 4;
  localparam int unsigned TLB_L1_WID     = 128;
  localparam int unsigned TLB_VALID_BIT  = TLB_L1_WID - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } tlb_l1_state_t;

endpackage

// File: rtl/thor2023_tlbram_l1_way.sv
// One way of the L1 TLB: ENTRIES x WID RAM with async read, one sync write port,
// and a registered output stage loaded with data chosen by the parent.
module thor2023_tlbram_l1_way
  import thor2023_mmu_pkg::*;
#(
  parameter int unsigned  ENTRIES = TLB_L1_ENTRIES,
  parameter int unsigned  WID     = TLB_L1_WID,
  localparam int unsigned AW      = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we_i,
  input  logic [AW-1:0]  wadr_i,
  input  logic [WID-1:0] wdat_i,
  input  logic [AW-1:0]  radr_i,
  output logic [WID-1:0] async_dat_o,
  input  logic           ld_en_i,
  input  logic [WID-1:0] ld_dat_i,
  output logic [WID-1:0] rd_dat_o
);

  logic [WID-1:0] mem_q [ENTRIES];
  logic [WID-1:0] rd_dat_q;

  // Storage has no reset; contents are defined only after an invalidate sweep.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wadr_i] <= wdat_i;
    end
  end

  assign async_dat_o = mem_q[radr_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat_q <= '0;
    end else if (ld_en_i) begin
      rd_dat_q <= ld_dat_i;
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/thor2023_tlbram_l1_nway.sv
// WAYS-way L1 TLB entry RAM: all-ways lookup port, single update port with
// round-robin refill way, and a hardware invalidate sweep on reset or command.
module thor2023_tlbram_l1_nway
  import thor2023_mmu_pkg::*;
#(
  parameter int unsigned  ENTRIES = TLB_L1_ENTRIES,
  parameter int unsigned  WAYS    = TLB_L1_WAYS,
  parameter int unsigned  WID     = TLB_L1_WID,
  parameter bit           BYPASS  = 1'b0,
  localparam int unsigned AW      = $clog2(ENTRIES),
  localparam int unsigned WW      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_adr,
  output logic [WAYS*WID-1:0] rd_dat,
  output logic                rd_vld,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_adr,
  input  logic                wr_auto,
  input  logic [WW-1:0]       wr_way,
  input  logic [WID-1:0]      wr_dat,
  output logic                wr_ack,
  output logic [WW-1:0]       wr_way_o,
  input  logic                inv_all,
  output logic                busy
);

  tlb_l1_state_t state_q, state_d;
  logic [AW-1:0] sidx_q, sidx_d;
  logic [WW-1:0] rr_q, rr_d;
  logic          rd_vld_q;
  logic          rd_ld_c;

  assign busy     = (state_q == SWEEP);
  assign wr_ack   = wr_en & ~busy & ~inv_all & ~rst;
  assign wr_way_o = (WAYS == 1) ? '0 : (wr_auto ? rr_q : wr_way);
  assign rd_ld_c  = rd_en & ~busy;

  // Sweep sequencing and refill way rotation.
  always_comb begin
    state_d = state_q;
    sidx_d  = sidx_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (inv_all) begin
          state_d = SWEEP;
          sidx_d  = '0;
        end
      end
      SWEEP: begin
        if (inv_all) begin
          sidx_d = '0;
        end else begin
          sidx_d = sidx_q + AW'(1);
          if (sidx_q == AW'(ENTRIES - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = SWEEP;
        sidx_d  = '0;
      end
    endcase
    if (WAYS > 1 && wr_ack && wr_auto) begin
      rr_d = (rr_q == WW'(WAYS - 1)) ? '0 : rr_q + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SWEEP;
      sidx_q   <= '0;
      rr_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sidx_q   <= sidx_d;
      rr_q     <= rr_d;
      rd_vld_q <= rd_ld_c;
    end
  end

  assign rd_vld = rd_vld_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic           hit_c;
    logic           we_c;
    logic           byp_c;
    logic [AW-1:0]  wadr_c;
    logic [WID-1:0] wdat_c;
    logic [WID-1:0] async_c;
    logic [WID-1:0] ld_dat_c;

    // The sweep owns the write port of every way while busy.
    assign hit_c    = wr_ack && (wr_way_o == WW'(w));
    assign we_c     = busy | hit_c;
    assign wadr_c   = busy ? sidx_q : wr_adr;
    assign wdat_c   = busy ? '0 : wr_dat;
    assign byp_c    = BYPASS && hit_c && (wr_adr == rd_adr);
    assign ld_dat_c = byp_c ? wr_dat : async_c;

    thor2023_tlbram_l1_way #(
      .ENTRIES (ENTRIES),
      .WID     (WID)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .we_i        (we_c),
      .wadr_i      (wadr_c),
      .wdat_i      (wdat_c),
      .radr_i      (rd_adr),
      .async_dat_o (async_c),
      .ld_en_i     (rd_ld_c),
      .ld_dat_i    (ld_dat_c),
      .rd_dat_o    (rd_dat[w*WID +: WID])
    );
  end

endmodule

// File: tb/tb_thor2023_tlbram_l1_nway.sv
// Directed bench for the L1 TLB RAM: one read_first and one bypass instance on shared stimulus.
module tb_thor2023_tlbram_l1_nway;

  localparam int unsigned ENTRIES = 64;
  localparam int unsigned WAYS    = 4;
  localparam int unsigned WID     = 128;
  localparam int unsigned AW      = 6;
  localparam int unsigned WW      = 2;
  localparam int unsigned NV      = 19;

  typedef struct {
    logic                rd_en;
    logic [AW-1:0]       rd_adr;
    logic                wr_en;
    logic [AW-1:0]       wr_adr;
    logic                wr_auto;
    logic [WW-1:0]       wr_way;
    logic [WID-1:0]      wr_dat;
    logic                exp_ack;
    logic [WW-1:0]       exp_way;
    logic                exp_vld;
    logic                chk_dat;
    logic [WAYS*WID-1:0] exp0;
    logic [WAYS*WID-1:0] exp1;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rd_en, wr_en, wr_auto, inv_all;
  logic [AW-1:0] rd_adr, wr_adr;
  logic [WW-1:0] wr_way;
  logic [WID-1:0] wr_dat;
  logic [WAYS*WID-1:0] dat0, dat1;
  logic vld0, vld1, ack0, ack1, busy0, busy1;
  logic [WW-1:0] way0, way1;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  thor2023_tlbram_l1_nway #(.ENTRIES(ENTRIES), .WAYS(WAYS), .WID(WID), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(dat0), .rd_vld(vld0),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_auto(wr_auto), .wr_way(wr_way), .wr_dat(wr_dat),
    .wr_ack(ack0), .wr_way_o(way0), .inv_all(inv_all), .busy(busy0));

  thor2023_tlbram_l1_nway #(.ENTRIES(ENTRIES), .WAYS(WAYS), .WID(WID), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(dat1), .rd_vld(vld1),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_auto(wr_auto), .wr_way(wr_way), .wr_dat(wr_dat),
    .wr_ack(ack1), .wr_way_o(way1), .inv_all(inv_all), .busy(busy1));

  function automatic logic [WAYS*WID-1:0] row(input logic [WID-1:0] w3, input logic [WID-1:0] w2,
                                              input logic [WID-1:0] w1, input logic [WID-1:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  function automatic vec_t mk(input logic re, input logic [AW-1:0] ra, input logic we,
                              input logic [AW-1:0] wa, input logic au, input logic [WW-1:0] ww,
                              input logic [WID-1:0] wd, input logic ack, input logic [WW-1:0] wy,
                              input logic vld, input logic cd, input logic [WAYS*WID-1:0] e0,
                              input logic [WAYS*WID-1:0] e1);
    vec_t v;
    v.rd_en = re; v.rd_adr = ra; v.wr_en = we; v.wr_adr = wa; v.wr_auto = au; v.wr_way = ww;
    v.wr_dat = wd; v.exp_ack = ack; v.exp_way = wy; v.exp_vld = vld; v.chk_dat = cd;
    v.exp0 = e0; v.exp1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [WAYS*WID-1:0] act, input logic [WAYS*WID-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; rd_adr = '0; wr_en = 1'b0; wr_adr = '0; wr_auto = 1'b0;
    wr_way = '0; wr_dat = '0; inv_all = 1'b0;
  endtask

  // Drive one vector after an edge, check the combinational write outputs, then the read result.
  task automatic apply(input vec_t v, input int idx);
    rd_en = v.rd_en; rd_adr = v.rd_adr; wr_en = v.wr_en; wr_adr = v.wr_adr;
    wr_auto = v.wr_auto; wr_way = v.wr_way; wr_dat = v.wr_dat;
    #1;
    chk($sformatf("v%0d wr_ack bypass0", idx), ack0, v.exp_ack);
    chk($sformatf("v%0d wr_ack bypass1", idx), ack1, v.exp_ack);
    if (v.exp_ack) begin
      chk($sformatf("v%0d wr_way_o bypass0", idx), way0, v.exp_way);
      chk($sformatf("v%0d wr_way_o bypass1", idx), way1, v.exp_way);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d rd_vld bypass0", idx), vld0, v.exp_vld);
    chk($sformatf("v%0d rd_vld bypass1", idx), vld1, v.exp_vld);
    if (v.chk_dat) begin
      chk($sformatf("v%0d rd_dat bypass0", idx), dat0, v.exp0);
      chk($sformatf("v%0d rd_dat bypass1", idx), dat1, v.exp1);
    end
  endtask

  initial begin
    logic [WAYS*WID-1:0] z;
    logic [WAYS*WID-1:0] r5;
    int n0, n1;
    z  = '0;
    r5 = row(128'd4, 128'd3, 128'd2, 128'd5);

    vecs[0]  = mk(1, 6'd0,  0, 6'd0,  0, 2'd0, 128'h0,    0, 2'd0, 1, 1, z, z);
    vecs[1]  = mk(1, 6'd31, 0, 6'd0,  0, 2'd0, 128'h0,    0, 2'd0, 1, 1, z, z);
    vecs[2]  = mk(1, 6'd63, 0, 6'd0,  0, 2'd0, 128'h0,    0, 2'd0, 1, 1, z, z);
    vecs[3]  = mk(0, 6'd0,  1, 6'd5,  1, 2'd0, 128'd1,    1, 2'd0, 0, 0, z, z);
    vecs[4]  = mk(0, 6'd0,  1, 6'd5,  1, 2'd0, 128'd2,    1, 2'd1, 0, 0, z, z);
    vecs[5]  = mk(0, 6'd0,  1, 6'd5,  1, 2'd0, 128'd3,    1, 2'd2, 0, 0, z, z);
    vecs[6]  = mk(0, 6'd0,  1, 6'd5,  1, 2'd0, 128'd4,    1, 2'd3, 0, 0, z, z);
    vecs[7]  = mk(0, 6'd0,  1, 6'd5,  1, 2'd0, 128'd5,    1, 2'd0, 0, 0, z, z);
    vecs[8]  = mk(1, 6'd5,  0, 6'd0,  0, 2'd0, 128'h0,    0, 2'd0, 1, 1, r5, r5);
    vecs[9]  = mk(0, 6'd0,  1, 6'd10, 0, 2'd2, 128'hABCD, 1, 2'd2, 0, 0, z, z);
    vecs[10] = mk(0, 6'd0,  1, 6'd12, 1, 2'd0, 128'h77,   1, 2'd1, 0, 0, z, z);
    vecs[11] = mk(1, 6'd10, 0, 6'd0,  0, 2'd0, 128'h0,    0, 2'd0, 1, 1,
                  row(0, 128'hABCD, 0, 0), row(0, 128'hABCD, 0, 0));
    vecs[12] = mk(1, 6'd12, 0, 6'd0,  0, 2'd0, 128'h0,    0, 2'd0, 1, 1,
                  row(0, 0, 128'h77, 0), row(0, 0, 128'h77, 0));
    vecs[13] = mk(0, 6'd0,  1, 6'd7,  0, 2'd1, 128'h11,   1, 2'd1, 0, 0, z, z);
    vecs[14] = mk(1, 6'd7,  1, 6'd7,  0, 2'd1, 128'h22,   1, 2'd1, 1, 1,
                  row(0, 0, 128'h11, 0), row(0, 0, 128'h22, 0));
    vecs[15] = mk(1, 6'd7,  0, 6'd0,  0, 2'd0, 128'h0,    0, 2'd0, 1, 1,
                  row(0, 0, 128'h22, 0), row(0, 0, 128'h22, 0));
    vecs[16] = mk(1, 6'd5,  1, 6'd8,  0, 2'd0, 128'h99,   1, 2'd0, 1, 1, r5, r5);
    vecs[17] = mk(1, 6'd8,  0, 6'd0,  0, 2'd0, 128'h0,    0, 2'd0, 1, 1,
                  row(0, 0, 0, 128'h99), row(0, 0, 0, 128'h99));
    vecs[18] = mk(0, 6'd8,  0, 6'd0,  0, 2'd0, 128'h0,    0, 2'd0, 0, 1,
                  row(0, 0, 0, 128'h99), row(0, 0, 0, 128'h99));

    // Reset: registered outputs clear, sweep runs for exactly ENTRIES cycles.
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_vld", vld0, 1'b0);
    chk("reset rd_dat", dat0, z);
    chk("reset busy", busy0, 1'b1);
    rst = 1'b0;
    n0 = 0; n1 = 0;
    while ((busy0 || busy1) && n0 < 300) begin
      n0 += int'(busy0); n1 += int'(busy1);
      @(posedge clk); #1;
    end
    chk("reset sweep length bypass0", 32'(n0), 32'(64));
    chk("reset sweep length bypass1", 32'(n1), 32'(64));

    for (int i = 0; i < int'(NV); i++) apply(vecs[i], i);
    idle_inputs();

    // Lockout: inv_all gates the write even in IDLE, then nothing is accepted while sweeping.
    inv_all = 1'b1; wr_en = 1'b1; wr_adr = 6'd5; wr_way = 2'd0; wr_dat = 128'hDEAD;
    rd_en = 1'b1; rd_adr = 6'd5;
    #1;
    chk("lockout ack during inv_all", ack0, 1'b0);
    @(posedge clk); #1;
    inv_all = 1'b0;
    n0 = 0;
    while (busy0 && n0 < 300) begin
      #1;
      chk("lockout wr_ack", {ack1, ack0}, 2'b00);
      @(posedge clk); #1;
      chk("lockout rd_vld", {vld1, vld0}, 2'b00);
      n0++;
    end
    idle_inputs();
    chk("lockout sweep length", 32'(n0), 32'(64));
    apply(mk(1, 6'd5,  0, 6'd0, 0, 2'd0, 128'h0, 0, 2'd0, 1, 1, z, z), 100);
    apply(mk(1, 6'd10, 0, 6'd0, 0, 2'd0, 128'h0, 0, 2'd0, 1, 1, z, z), 101);

    // inv_all at sweep cycle 30 restarts the sweep.
    inv_all = 1'b1;
    @(posedge clk); #1;
    n0 = 0;
    while (busy0 && n0 < 400) begin
      inv_all = (n0 == 30);
      @(posedge clk); #1;
      n0++;
    end
    inv_all = 1'b0;
    chk("inv_all restart busy cycles", 32'(n0), 32'(95));

    // rst blocks a write in IDLE, and rst at sweep cycle 10 restarts the sweep.
    rst = 1'b1; wr_en = 1'b1; wr_adr = 6'd3; wr_dat = 128'h5A;
    #1;
    chk("rst gates wr_ack", {ack1, ack0}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    n0 = 0; n1 = 0;
    while ((busy0 || busy1) && n0 < 400) begin
      rst = (n0 == 10);
      n1 += int'(busy1);
      @(posedge clk); #1;
      n0++;
    end
    rst = 1'b0;
    chk("rst restart busy cycles bypass0", 32'(n0), 32'(75));
    chk("rst restart busy cycles bypass1", 32'(n1), 32'(75));
    apply(mk(1, 6'd3, 0, 6'd0, 0, 2'd0, 128'h0, 0, 2'd0, 1, 1, z, z), 102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
